// File: rtl/ins_fetch.sv
// ins_fetch: program counter plus single-outstanding instruction memory fetch feeding a
// 2-entry {pc, instr} FIFO. Define IFETCH_MISALIGN_CHECK_EN to trap misaligned redirects.
module ins_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction_Code,
    output logic        PC_EN,
    output logic [31:0] ins_pc,
    input  logic        dec_ready,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    output logic        fetch_fault
);

`ifdef IFETCH_MISALIGN_CHECK_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_FAULT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, iss_pc_q, iss_pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] hpc_q, hpc_d, hins_q, hins_d;
    logic [31:0] tpc_q, tpc_d, tins_q, tins_d;
    logic [31:0] tgt;
    logic        gnt, push, pop, flush, in_fault;

    // Credit: nothing outstanding in S_REQ, so only the FIFO fill limits issue.
    assign imem_req         = (state_q == S_REQ) && (cnt_q != 2'd2);
    assign gnt              = imem_req && imem_gnt;
    assign imem_addr        = pc_q;
    assign PC_EN            = (cnt_q != 2'd0);
    assign ins_pc           = hpc_q;
    assign Instruction_Code = hins_q;

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic fault_q, fault_d;
    assign tgt         = jmp_target;
    assign in_fault    = (state_q == S_FAULT);
    assign fetch_fault = fault_q;
`else
    logic fault_q, fault_d;
    assign tgt         = jmp_target & 32'hFFFF_FFFC;
    assign in_fault    = 1'b0;
    assign fetch_fault = fault_q;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        iss_pc_d = iss_pc_q;
        fault_d  = fault_q;
        push     = 1'b0;
        pop      = PC_EN && dec_ready;
        flush    = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ: if (gnt) begin
                state_d  = S_WAIT;
                iss_pc_d = pc_q;
                pc_d     = pc_q + 32'd4;
            end
            S_WAIT: if (imem_rvalid) begin
                state_d = S_REQ;
                push    = 1'b1;
            end
            S_DRAIN: if (imem_rvalid) state_d = S_REQ;
            default: state_d = state_q;
        endcase
        // A redirect overrides everything; a response arriving with it retires the credit.
        if (jmp_valid && !in_fault) begin
            flush = 1'b1;
            push  = 1'b0;
            pop   = 1'b0;
            pc_d  = tgt;
            if ((state_q == S_REQ && gnt) ||
                ((state_q == S_WAIT || state_q == S_DRAIN) && !imem_rvalid))
                state_d = S_DRAIN;
            else
                state_d = S_REQ;
`ifdef IFETCH_MISALIGN_CHECK_EN
            if (tgt[1:0] != 2'b00) begin
                state_d = S_FAULT;
                fault_d = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        hpc_d  = hpc_q;
        hins_d = hins_q;
        tpc_d  = tpc_q;
        tins_d = tins_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else if (push && pop) begin
            if (cnt_q == 2'd1) begin
                hpc_d  = iss_pc_q;
                hins_d = imem_rdata;
            end else begin
                hpc_d  = tpc_q;
                hins_d = tins_q;
                tpc_d  = iss_pc_q;
                tins_d = imem_rdata;
            end
        end else if (push) begin
            if (cnt_q == 2'd0) begin
                hpc_d  = iss_pc_q;
                hins_d = imem_rdata;
            end else begin
                tpc_d  = iss_pc_q;
                tins_d = imem_rdata;
            end
            cnt_d = cnt_q + 2'd1;
        end else if (pop) begin
            hpc_d  = tpc_q;
            hins_d = tins_q;
            cnt_d  = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            iss_pc_q <= 32'd0;
            cnt_q    <= 2'd0;
            hpc_q    <= 32'd0;
            hins_q   <= 32'd0;
            tpc_q    <= 32'd0;
            tins_q   <= 32'd0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            iss_pc_q <= iss_pc_d;
            cnt_q    <= cnt_d;
            hpc_q    <= hpc_d;
            hins_q   <= hins_d;
            tpc_q    <= tpc_d;
            tins_q   <= tins_d;
            fault_q  <= fault_d;
        end
    end

endmodule

// File: doc/ins_fetch.md
# ins_fetch

Instruction fetch unit that feeds the instruction decoder. It holds the program counter and issues word reads to instruction memory with at most one request outstanding. Returned words are buffered in a 2-entry FIFO and presented to the decoder as `Instruction_Code`, qualified by `PC_EN`. Jump redirects flush the FIFO and discard any in-flight response.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded at reset; must be word-aligned.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  read request valid.
- `imem_addr`  out  32  word address of the request (current PC).
- `imem_gnt`  in  1  request accepted when `imem_req && imem_gnt`.
- `imem_rvalid`  in  1  read data valid; ≥1 cycle after grant, exactly once per grant.
- `imem_rdata`  in  32  instruction word.
- `Instruction_Code`  out  32  FIFO head instruction to the decoder.
- `PC_EN`  out  1  head valid; decoder enable.
- `ins_pc`  out  32  PC of the head instruction.
- `dec_ready`  in  1  decoder consumes the head when `PC_EN && dec_ready`.
- `jmp_valid`  in  1  redirect request, one-cycle pulse.
- `jmp_target`  in  32  redirect PC.
- `fetch_fault`  out  1  misaligned redirect flag (see Configuration).

## Operation
- FIFO: 2 entries of {pc, instr}, registered outputs from the head. `PC_EN` = count≠0.
- `pc` is the address of the next request. It advances by 4 on each grant.
- Credit rule: assert `imem_req` only if count + outstanding(0/1) < 2.
- States:
  - S_IDLE: reset state. Go to S_REQ the next cycle.
  - S_REQ: `imem_req` asserted when credit allows. On grant, go to S_WAIT.
  - S_WAIT: `imem_req`=0. On `imem_rvalid`, push {issued pc, `imem_rdata`} and go to S_REQ.
  - S_DRAIN: waits for the stale response and drops it on `imem_rvalid`, then goes to S_REQ.
  - S_FAULT: only when the macro is enabled. All outputs are held idle until `rst`.
- Redirect (`jmp_valid`) has priority over every other event in the same cycle:
  - Flush the FIFO (count←0, `PC_EN`←0 next cycle) and set `pc`←`jmp_target`.
  - From S_WAIT, or from S_REQ with a same-cycle grant: go to S_DRAIN.
  - From S_REQ without a grant: stay in S_REQ.
  - In S_DRAIN: update `pc` and stay in S_DRAIN. A same-cycle `imem_rvalid` completes the drain, so go to S_REQ.
  - A same-cycle `imem_rvalid` in S_WAIT is discarded.
  - A same-cycle pop is ignored.
- Simultaneous push and pop: count is unchanged, data shifts, head becomes the older remaining entry.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0 silently.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `PC_EN`=0, `Instruction_Code`=0, `ins_pc`=0, `fetch_fault`=0. State is S_IDLE, count=0.
- First `imem_req` is asserted 2 cycles after the `rst` deassertion edge (IDLE→REQ).
- Response to decoder: `imem_rvalid` in cycle N gives `PC_EN`=1 in cycle N+1.
- Throughput with 1-cycle memory latency: one instruction per 2 cycles (grant, then response).
- `imem_addr` is stable while `imem_req`=1 and not granted.
- `rst` mid-operation returns to reset values on the next edge. A stale response after reset is ignored: S_IDLE/S_REQ ignore `imem_rvalid` when nothing is outstanding.
- After redirect in cycle R with nothing outstanding, `imem_req` with `imem_addr`=`jmp_target` is asserted in R+1.

## Configuration
- `IFETCH_MISALIGN_CHECK_EN`:
  - Defined: a redirect with `jmp_target[1:0]`≠0 sets `fetch_fault`=1 from the next cycle and enters S_FAULT. S_FAULT holds `imem_req`=0 and `PC_EN`=0 until `rst`.
  - Undefined: `jmp_target[1:0]` is forced to 2'b00, `fetch_fault` is tied to 0, and S_FAULT does not exist.

## Test plan
- Reset, `imem_gnt`=1, 1-cycle memory returning addr^32'hA5A5_0000, `dec_ready`=1 -> `ins_pc` sequence 0, 4, 8; `Instruction_Code` 32'hA5A5_0000, 32'hA5A5_0004, 32'hA5A5_0008; `PC_EN` high every other cycle.
- `dec_ready`=0 throughout -> exactly 2 entries fill (pc 0, 4); `imem_req` stays 0 afterward; raising `dec_ready` pops pc 0 and then pc 4 in order.
- Redirect to 32'h0000_0100 while in S_WAIT, with the response arriving 3 cycles later -> that response is dropped; the next request has `imem_addr`=32'h100; the first `ins_pc` after the flush is 32'h100.
- Redirect on the same cycle as `imem_rvalid` and a pop -> FIFO is empty next cycle; no stale instruction appears; the next request goes to the target.
- `RESET_PC`=32'hFFFF_FFFC -> second request address is 32'h0000_0000.
- With `IFETCH_MISALIGN_CHECK_EN`: redirect to 32'h102 -> `fetch_fault`=1 next cycle; no further `imem_req`; `rst` clears the fault. Without it: next request address is 32'h100.
